// File: rtl/prog_mem_resp_if.sv
// Request/response bus between the CPU and the program memory.
// Signal names keep the memory-side _i/_o direction suffixes.
interface prog_mem_resp_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              ack_o;
    logic              busy_o;
    logic              err_o;

    // CPU side: drives the request, observes the response.
    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o, busy_o, err_o
    );

    // Memory side: observes the request, drives the response.
    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o, busy_o, err_o
    );
endinterface

// File: rtl/prog_mem_resp.sv
// Program memory with fixed-latency request/acknowledge handshake.
// IDLE accepts a request, WAIT burns WAIT cycles, RESP pulses ack for one
// cycle. Reads and writes take effect on the edge that enters RESP.
module prog_mem_resp #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int WAIT   = 2
) (
    input  logic          clk_i,
    input  logic          reset,
    prog_mem_resp_if.slave bus
);
    // Index width covers DEPTH; DEPTH <= 2**ADDR_W keeps it within ADDR_W.
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_M1 = 4'(WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                enter_resp;
    logic                oor;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [0:(2**IDX_W)-1];

    // Next state, counter and request latch. The *_d latch values are the
    // ones in force on the RESP-entry edge, which matters when WAIT=0 and
    // the request is latched on that same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RESP is only ever entered from IDLE or WAIT, so this marks the entry edge.
    // Out-of-range uses the full unsigned address so high words never alias.
    always_comb begin
        enter_resp = (state_d == S_RESP);
        oor        = ({1'b0, addr_d} >= DEPTH_V);
        idx        = addr_d[IDX_W-1:0];
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (enter_resp) begin
            err_d = oor;
            if (!we_d) rdata_d = oor ? '0 : mem[idx];
        end
    end

    // Control and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory write on RESP entry; contents are never cleared, and no write
    // can land while reset is held.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
        end else if (enter_resp && we_d && !oor) begin
            mem[idx] <= wdata_d;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ack_o   = (state_q == S_RESP);
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.err_o   = (state_q == S_RESP) && err_q;

endmodule
